// File: rtl/main_memory_ctrl.sv
// Latency-modelled main memory: one outstanding request with a valid/ready response and a free-running cache write-back port.
// Define MEM_ADDR_CHECK_EN to flag out-of-range addresses as errors; by default addresses wrap modulo DEPTH.
module main_memory_ctrl #(
   parameter int DATA_W    = 4,
   parameter int ADDR_W    = 4,
   parameter int DEPTH     = 8,
   parameter int BASE_ADDR = 1,
   parameter int PID_W     = 2,
   parameter int LATENCY   = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [PID_W-1:0]  ReqProc,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [DATA_W-1:0] ReqData,
   input  logic              WbValid,
   input  logic [ADDR_W-1:0] WbAddr,
   input  logic [DATA_W-1:0] WbData,
   output logic              RespValid,
   input  logic              RespReady,
   output logic [PID_W-1:0]  RespProc,
   output logic [ADDR_W-1:0] RespAddr,
   output logic [DATA_W-1:0] RespData,
   output logic              RespErr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                reqWrite_q, reqWrite_d;
   logic [PID_W-1:0]    reqProc_q, reqProc_d;
   logic [ADDR_W-1:0]   reqAddr_q, reqAddr_d;
   logic [DATA_W-1:0]   reqData_q, reqData_d;
   logic [PID_W-1:0]    respProc_q, respProc_d;
   logic [ADDR_W-1:0]   respAddr_q, respAddr_d;
   logic [DATA_W-1:0]   respData_q, respData_d;
   logic                respErr_q, respErr_d;

   // Entries hold (contents XOR power-up image), so an all-zero array reads back as entry[i] = i+1.
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]   reqOff, wbOff;
   logic [IDX_W-1:0]    reqIdx, wbIdx;
   logic                reqOk, wbOk, commit;

   function automatic logic [DATA_W-1:0] initVal(input logic [IDX_W-1:0] idx);
      return DATA_W'(32'(idx) + 32'd1);
   endfunction

   assign reqOff = reqAddr_q - ADDR_W'(BASE_ADDR);
   assign wbOff  = WbAddr - ADDR_W'(BASE_ADDR);
   assign reqIdx = IDX_W'(32'(reqOff) % DEPTH);
   assign wbIdx  = IDX_W'(32'(wbOff) % DEPTH);

`ifdef MEM_ADDR_CHECK_EN
   assign reqOk = 32'(reqOff) < DEPTH;
   assign wbOk  = 32'(wbOff) < DEPTH;
`else
   assign reqOk = 1'b1;
   assign wbOk  = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reqWrite_d = reqWrite_q;
      reqProc_d  = reqProc_q;
      reqAddr_d  = reqAddr_q;
      reqData_d  = reqData_q;
      respProc_d = respProc_q;
      respAddr_d = respAddr_q;
      respData_d = respData_q;
      respErr_d  = respErr_q;
      commit     = 1'b0;
      case (state_q)
         IDLE: begin
            if (ReqValid) begin
               reqWrite_d = ReqWrite;
               reqProc_d  = ReqProc;
               reqAddr_d  = ReqAddr;
               reqData_d  = ReqData;
               cnt_d      = CNT_W'(LATENCY - 1);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               commit     = 1'b1;
               state_d    = RESP;
               respProc_d = reqProc_q;
               respAddr_d = reqAddr_q;
               respErr_d  = !reqOk;
               // A same-edge write-back to the entry being read is forwarded.
               if (!reqOk)
                  respData_d = '0;
               else if (reqWrite_q)
                  respData_d = reqData_q;
               else if (WbValid && wbOk && (wbIdx == reqIdx))
                  respData_d = WbData;
               else
                  respData_d = mem_q[reqIdx] ^ initVal(reqIdx);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (RespReady)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         reqWrite_q <= 1'b0;
         reqProc_q  <= '0;
         reqAddr_q  <= '0;
         reqData_q  <= '0;
         respProc_q <= '0;
         respAddr_q <= '0;
         respData_q <= '0;
         respErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         reqWrite_q <= reqWrite_d;
         reqProc_q  <= reqProc_d;
         reqAddr_q  <= reqAddr_d;
         reqData_q  <= reqData_d;
         respProc_q <= respProc_d;
         respAddr_q <= respAddr_d;
         respData_q <= respData_d;
         respErr_q  <= respErr_d;
      end
   end

   // The request write is issued last so it overrides a same-edge write-back to the same entry.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         if (WbValid && wbOk)
            mem_q[wbIdx] <= WbData ^ initVal(wbIdx);
         if (commit && reqWrite_q && reqOk)
            mem_q[reqIdx] <= reqData_q ^ initVal(reqIdx);
      end
   end

   assign ReqReady  = (state_q == IDLE);
   assign RespValid = (state_q == RESP);
   assign RespProc  = respProc_q;
   assign RespAddr  = respAddr_q;
   assign RespData  = respData_q;
   assign RespErr   = respErr_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed scenarios plus randomized traffic against an array-based memory model.
module tb_main_memory_ctrl;

   localparam int DATA_W    = 4;
   localparam int ADDR_W    = 4;
   localparam int DEPTH     = 8;
   localparam int BASE_ADDR = 1;
   localparam int PID_W     = 2;
   localparam int LATENCY   = 2;

   logic              Clock = 1'b0;
   logic              Reset;
   logic              ReqValid, ReqReady, ReqWrite;
   logic [PID_W-1:0]  ReqProc;
   logic [ADDR_W-1:0] ReqAddr;
   logic [DATA_W-1:0] ReqData;
   logic              WbValid;
   logic [ADDR_W-1:0] WbAddr;
   logic [DATA_W-1:0] WbData;
   logic              RespValid, RespReady, RespErr;
   logic [PID_W-1:0]  RespProc;
   logic [ADDR_W-1:0] RespAddr;
   logic [DATA_W-1:0] RespData;

   main_memory_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
      .BASE_ADDR(BASE_ADDR), .PID_W(PID_W), .LATENCY(LATENCY)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqProc(ReqProc), .ReqAddr(ReqAddr), .ReqData(ReqData),
      .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
      .RespValid(RespValid), .RespReady(RespReady),
      .RespProc(RespProc), .RespAddr(RespAddr), .RespData(RespData), .RespErr(RespErr)
   );

   always #5 Clock = ~Clock;

   int compareCount  = 0;
   int mismatchCount = 0;
   int model [DEPTH];

   bit                nextPend = 1'b0;
   logic              nextWrite;
   logic [PID_W-1:0]  nextProc;
   logic [ADDR_W-1:0] nextAddr;
   logic [DATA_W-1:0] nextData;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic int offsetOf(input int a);
      return (a - BASE_ADDR + (1 << ADDR_W)) % (1 << ADDR_W);
   endfunction

   function automatic bit addrOk(input int a);
`ifdef MEM_ADDR_CHECK_EN
      return offsetOf(a) < DEPTH;
`else
      return (a >= 0);
`endif
   endfunction

   function automatic int slotOf(input int a);
      return offsetOf(a) % DEPTH;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic pickWb(input bit en);
      if (en && ($urandom_range(0, 1) == 1)) begin
         WbValid = 1'b1;
         WbAddr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
         WbData  = DATA_W'($urandom);
      end else begin
         WbValid = 1'b0;
      end
   endtask

   // Applies whatever write-back is on the bus to the model for the coming edge.
   task automatic modelWb();
      if (WbValid && !Reset && addrOk(int'(WbAddr)))
         model[slotOf(int'(WbAddr))] = int'(WbData);
   endtask

   task automatic applyStimulus(input logic wr, input logic [PID_W-1:0] proc, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input int hold, input bit randWb,
                                input bit forceWb, input logic [ADDR_W-1:0] fAddr, input logic [DATA_W-1:0] fData);
      int                seen = 0;
      logic [DATA_W-1:0] expData = '0;
      logic              expErr = 1'b0;
      checkOutput("reqReadyIdle", 32'(ReqReady), 32'd1);
      ReqValid = 1'b1;
      ReqWrite = wr;
      ReqProc  = proc;
      ReqAddr  = addr;
      ReqData  = data;
      pickWb(randWb);
      modelWb();
      tick();
      ReqValid = 1'b0;
      checkOutput("reqReadyBusy", 32'(ReqReady), 32'd0);
      for (int cyc = 1; cyc <= LATENCY + 4 && seen == 0; cyc++) begin
         if (cyc == LATENCY && forceWb) begin
            WbValid = 1'b1;
            WbAddr  = fAddr;
            WbData  = fData;
         end else begin
            pickWb(randWb);
         end
         if (cyc == LATENCY) begin
            expErr = !addrOk(int'(addr));
            if (expErr)
               expData = '0;
            else if (wr)
               expData = data;
            else if (WbValid && addrOk(int'(WbAddr)) && slotOf(int'(WbAddr)) == slotOf(int'(addr)))
               expData = WbData;
            else
               expData = DATA_W'(model[slotOf(int'(addr))]);
         end
         modelWb();
         if (cyc == LATENCY && wr && addrOk(int'(addr)))
            model[slotOf(int'(addr))] = int'(data);
         tick();
         if (RespValid)
            seen = cyc;
      end
      WbValid = 1'b0;
      checkOutput("latency", 32'(seen), 32'(LATENCY));
      checkOutput("respProc", 32'(RespProc), 32'(proc));
      checkOutput("respAddr", 32'(RespAddr), 32'(addr));
      checkOutput("respData", 32'(RespData), 32'(expData));
      checkOutput("respErr", 32'(RespErr), 32'(expErr));
      RespReady = 1'b0;
      if (nextPend) begin
         ReqValid = 1'b1;
         ReqWrite = nextWrite;
         ReqProc  = nextProc;
         ReqAddr  = nextAddr;
         ReqData  = nextData;
      end
      for (int h = 0; h < hold; h++) begin
         pickWb(randWb);
         modelWb();
         tick();
         checkOutput("holdValid", 32'(RespValid), 32'd1);
         checkOutput("holdData", 32'(RespData), 32'(expData));
         checkOutput("holdProc", 32'(RespProc), 32'(proc));
         checkOutput("holdReqReady", 32'(ReqReady), 32'd0);
      end
      RespReady = 1'b1;
      pickWb(randWb);
      modelWb();
      tick();
      RespReady = 1'b0;
      WbValid   = 1'b0;
      checkOutput("handshakeValid", 32'(RespValid), 32'd0);
      checkOutput("handshakeReady", 32'(ReqReady), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Reset     = 1'b1;
      ReqValid  = 1'b0;
      ReqWrite  = 1'b0;
      ReqProc   = '0;
      ReqAddr   = '0;
      ReqData   = '0;
      WbValid   = 1'b0;
      WbAddr    = '0;
      WbData    = '0;
      RespReady = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         model[i] = (i + 1) % (1 << DATA_W);
      tick();
      tick();
      checkOutput("rstReqReady", 32'(ReqReady), 32'd1);
      checkOutput("rstRespValid", 32'(RespValid), 32'd0);
      checkOutput("rstRespProc", 32'(RespProc), 32'd0);
      checkOutput("rstRespAddr", 32'(RespAddr), 32'd0);
      checkOutput("rstRespData", 32'(RespData), 32'd0);
      checkOutput("rstRespErr", 32'(RespErr), 32'd0);
      Reset = 1'b0;

      $display("[TB] directed scenarios");
      applyStimulus(1'b0, 2'd0, 4'd1, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b1, 2'd1, 4'd3, 4'hA, 0, 1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b0, 2'd1, 4'd3, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b0, 2'd3, 4'd5, 4'd0, 0, 1'b0, 1'b1, 4'd5, 4'h7);
      applyStimulus(1'b1, 2'd2, 4'd6, 4'hC, 1, 1'b0, 1'b1, 4'd6, 4'h3);
      applyStimulus(1'b0, 2'd0, 4'd6, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

      nextPend  = 1'b1;
      nextWrite = 1'b0;
      nextProc  = 2'd2;
      nextAddr  = 4'd3;
      nextData  = 4'd0;
      applyStimulus(1'b0, 2'd1, 4'd4, 4'd0, 3, 1'b0, 1'b0, 4'd0, 4'd0);
      nextPend  = 1'b0;
      applyStimulus(1'b0, 2'd2, 4'd3, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

      $display("[TB] reset during a pending write");
      ReqValid = 1'b1;
      ReqWrite = 1'b1;
      ReqProc  = 2'd1;
      ReqAddr  = 4'd2;
      ReqData  = 4'hF;
      tick();
      ReqValid = 1'b0;
      tick();
      Reset   = 1'b1;
      WbValid = 1'b1;
      WbAddr  = 4'd6;
      WbData  = 4'd0;
      tick();
      Reset   = 1'b0;
      WbValid = 1'b0;
      checkOutput("rstMidValid", 32'(RespValid), 32'd0);
      checkOutput("rstMidReady", 32'(ReqReady), 32'd1);
      checkOutput("rstMidData", 32'(RespData), 32'd0);
      for (int i = 0; i < LATENCY + 2; i++) begin
         tick();
         checkOutput("rstNoResp", 32'(RespValid), 32'd0);
      end
      applyStimulus(1'b0, 2'd0, 4'd2, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b0, 2'd0, 4'd6, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

      $display("[TB] boundary addresses");
      applyStimulus(1'b0, 2'd1, 4'd9, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b0, 2'd2, 4'd0, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b0, 2'd3, 4'd8, 4'd0, 0, 1'b0, 1'b0, 4'd0, 4'd0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), PID_W'($urandom), ADDR_W'($urandom),
                       DATA_W'($urandom), $urandom_range(0, 3), 1'b1, 1'b0, 4'd0, 4'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
